// File: rtl/riscv_biu_arbiter.sv
// ---------------------------------------------------------------------------
// riscv_biu_arbiter
//   Two-master (instruction fetch "if", data "dc") to one-slave arbiter on the
//   core-side BIU bus. One burst is granted at a time. The owner keeps the bus
//   until every beat is acknowledged or an error ends the burst, so ack, read
//   data and error always return to the master that issued the burst.
//
//   Optional feature macro: BIU_ARB_RR_EN
//     undefined : fixed priority, dc over if
//     defined   : round-robin between the two masters when both strobe
//   A locked burst always re-grants its owner next (if it strobes) in both
//   builds.
//
// Ports
//   HCLK, HRESET              clock, asynchronous active-high reset
//   if_biu_* / dc_biu_*       master-side BIU ports (stb, adri, size, type,
//                             prot, lock, we, d in; stb_ack, d_ack, adro, q,
//                             ack, err out)
//   biu_*                     slave-side BIU port towards the AXI4 bridge
// ---------------------------------------------------------------------------
module riscv_biu_arbiter #(
  parameter int XLEN = 64,
  parameter int PLEN = 64
) (
  input  logic            HCLK,
  input  logic            HRESET,

  // instruction-fetch master
  input  logic            if_biu_stb_i,
  output logic            if_biu_stb_ack_o,
  output logic            if_biu_d_ack_o,
  input  logic [PLEN-1:0] if_biu_adri_i,
  output logic [PLEN-1:0] if_biu_adro_o,
  input  logic [2:0]      if_biu_size_i,
  input  logic [2:0]      if_biu_type_i,
  input  logic [2:0]      if_biu_prot_i,
  input  logic            if_biu_lock_i,
  input  logic            if_biu_we_i,
  input  logic [XLEN-1:0] if_biu_d_i,
  output logic [XLEN-1:0] if_biu_q_o,
  output logic            if_biu_ack_o,
  output logic            if_biu_err_o,

  // data master
  input  logic            dc_biu_stb_i,
  output logic            dc_biu_stb_ack_o,
  output logic            dc_biu_d_ack_o,
  input  logic [PLEN-1:0] dc_biu_adri_i,
  output logic [PLEN-1:0] dc_biu_adro_o,
  input  logic [2:0]      dc_biu_size_i,
  input  logic [2:0]      dc_biu_type_i,
  input  logic [2:0]      dc_biu_prot_i,
  input  logic            dc_biu_lock_i,
  input  logic            dc_biu_we_i,
  input  logic [XLEN-1:0] dc_biu_d_i,
  output logic [XLEN-1:0] dc_biu_q_o,
  output logic            dc_biu_ack_o,
  output logic            dc_biu_err_o,

  // bridge-side slave port
  output logic            biu_stb_o,
  input  logic            biu_stb_ack_i,
  input  logic            biu_d_ack_i,
  output logic [PLEN-1:0] biu_adri_o,
  input  logic [PLEN-1:0] biu_adro_i,
  output logic [2:0]      biu_size_o,
  output logic [2:0]      biu_type_o,
  output logic [2:0]      biu_prot_o,
  output logic            biu_lock_o,
  output logic            biu_we_o,
  output logic [XLEN-1:0] biu_d_o,
  input  logic [XLEN-1:0] biu_q_i,
  input  logic            biu_ack_i,
  input  logic            biu_err_i
);

  // Burst type encodings of the BIU package
  localparam logic [2:0] SINGLE = 3'b000;
  localparam logic [2:0] INCR   = 3'b001;
  localparam logic [2:0] WRAP4  = 3'b010;
  localparam logic [2:0] INCR4  = 3'b011;
  localparam logic [2:0] WRAP8  = 3'b100;
  localparam logic [2:0] INCR8  = 3'b101;
  localparam logic [2:0] WRAP16 = 3'b110;
  localparam logic [2:0] INCR16 = 3'b111;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_DC = 2'd2
  } state_t;

  state_t      r_state;
  logic        r_owner_if;   // 1: if owns (or last owned) the bus, 0: dc
  logic [4:0]  r_beat_cnt;
  logic        r_lock_hold;  // last burst ended locked
  logic        r_lock_if;    // owner of that locked burst
`ifdef BIU_ARB_RR_EN
  logic        r_rr_last_if; // last grant went to if
`endif

  logic        w_idle;
  logic        w_sel_if;
  logic        w_mux_if;
  logic        w_sel_stb;
  logic        w_grant;
  logic        w_owner_lock;
  logic        w_busy_if;
  logic        w_busy_dc;

  function automatic logic [4:0] burst_len(input logic [2:0] btype);
    case (btype)
      SINGLE, INCR:   burst_len = 5'd1;
      WRAP4,  INCR4:  burst_len = 5'd4;
      WRAP8,  INCR8:  burst_len = 5'd8;
      WRAP16, INCR16: burst_len = 5'd16;
      default:        burst_len = 5'd1;
    endcase
  endfunction

  assign w_idle = (r_state == IDLE);

  // Grant selection while idle. A pending lock re-grants its owner first;
  // otherwise dc wins (or round-robin decides when both strobe).
  always_comb begin
    w_sel_if = 1'b0;
    if (r_lock_hold && r_lock_if && if_biu_stb_i) begin
      w_sel_if = 1'b1;
    end else if (r_lock_hold && !r_lock_if && dc_biu_stb_i) begin
      w_sel_if = 1'b0;
`ifdef BIU_ARB_RR_EN
    end else if (dc_biu_stb_i && if_biu_stb_i) begin
      w_sel_if = ~r_rr_last_if;
`endif
    end else if (!dc_biu_stb_i && if_biu_stb_i) begin
      w_sel_if = 1'b1;
    end
  end

  // Request fields follow the selected master while idle and the owner while
  // busy, so write data of later beats keeps flowing from the owner.
  assign w_mux_if   = w_idle ? w_sel_if : r_owner_if;

  assign biu_adri_o = w_mux_if ? if_biu_adri_i : dc_biu_adri_i;
  assign biu_size_o = w_mux_if ? if_biu_size_i : dc_biu_size_i;
  assign biu_type_o = w_mux_if ? if_biu_type_i : dc_biu_type_i;
  assign biu_prot_o = w_mux_if ? if_biu_prot_i : dc_biu_prot_i;
  assign biu_lock_o = w_mux_if ? if_biu_lock_i : dc_biu_lock_i;
  assign biu_we_o   = w_mux_if ? if_biu_we_i   : dc_biu_we_i;
  assign biu_d_o    = w_mux_if ? if_biu_d_i    : dc_biu_d_i;

  // Strobe is suppressed during reset even though the select is combinational
  assign w_sel_stb  = w_sel_if ? if_biu_stb_i : dc_biu_stb_i;
  assign biu_stb_o  = w_idle & w_sel_stb & ~HRESET;
  assign w_grant    = biu_stb_o & biu_stb_ack_i;

  assign if_biu_stb_ack_o = w_grant &  w_sel_if;
  assign dc_biu_stb_ack_o = w_grant & ~w_sel_if;

  // Responses reach only the owner and only while a burst is in flight
  assign w_busy_if = (r_state == BUSY_IF);
  assign w_busy_dc = (r_state == BUSY_DC);

  assign if_biu_ack_o   = w_busy_if & biu_ack_i;
  assign dc_biu_ack_o   = w_busy_dc & biu_ack_i;
  assign if_biu_d_ack_o = w_busy_if & biu_d_ack_i;
  assign dc_biu_d_ack_o = w_busy_dc & biu_d_ack_i;
  assign if_biu_err_o   = w_busy_if & biu_err_i;
  assign dc_biu_err_o   = w_busy_dc & biu_err_i;

  assign if_biu_adro_o  =  r_owner_if ? biu_adro_i : '0;
  assign dc_biu_adro_o  = !r_owner_if ? biu_adro_i : '0;

  // Read data is qualified by ack at the master, so it fans out unmuxed
  assign if_biu_q_o     = biu_q_i;
  assign dc_biu_q_o     = biu_q_i;

  assign w_owner_lock   = r_owner_if ? if_biu_lock_i : dc_biu_lock_i;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_state      <= IDLE;
      r_owner_if   <= 1'b0;
      r_beat_cnt   <= 5'd0;
      r_lock_hold  <= 1'b0;
      r_lock_if    <= 1'b0;
`ifdef BIU_ARB_RR_EN
      r_rr_last_if <= 1'b1;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant) begin
            r_state     <= w_sel_if ? BUSY_IF : BUSY_DC;
            r_owner_if  <= w_sel_if;
            r_beat_cnt  <= burst_len(biu_type_o);
            r_lock_hold <= 1'b0;
`ifdef BIU_ARB_RR_EN
            r_rr_last_if <= w_sel_if;
`endif
          end
        end
        BUSY_IF, BUSY_DC: begin
          // An error aborts the burst; remaining beats are dropped
          if (biu_err_i) begin
            r_state     <= IDLE;
            r_beat_cnt  <= 5'd0;
            r_lock_hold <= w_owner_lock;
            r_lock_if   <= r_owner_if;
          end else if (biu_ack_i) begin
            r_beat_cnt <= r_beat_cnt - 5'd1;
            if (r_beat_cnt == 5'd1) begin
              r_state     <= IDLE;
              r_lock_hold <= w_owner_lock;
              r_lock_if   <= r_owner_if;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_biu_arbiter.sv
module tb_riscv_biu_arbiter;
  localparam int XLEN = 64;
  localparam int PLEN = 64;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic            if_stb, if_stb_ack, if_d_ack, if_lock, if_we, if_ack, if_err;
  logic [PLEN-1:0] if_adri, if_adro;
  logic [2:0]      if_size, if_type, if_prot;
  logic [XLEN-1:0] if_d, if_q;
  logic            dc_stb, dc_stb_ack, dc_d_ack, dc_lock, dc_we, dc_ack, dc_err;
  logic [PLEN-1:0] dc_adri, dc_adro;
  logic [2:0]      dc_size, dc_type, dc_prot;
  logic [XLEN-1:0] dc_d, dc_q;
  logic            b_stb, b_stb_ack, b_d_ack, b_lock, b_we, b_ack, b_err;
  logic [PLEN-1:0] b_adri, b_adro;
  logic [2:0]      b_size, b_type, b_prot;
  logic [XLEN-1:0] b_d, b_q;

  int n_tests = 0;
  int n_fail  = 0;

  riscv_biu_arbiter #(.XLEN(XLEN), .PLEN(PLEN)) dut (
    .HCLK(clk), .HRESET(rst),
    .if_biu_stb_i(if_stb), .if_biu_stb_ack_o(if_stb_ack), .if_biu_d_ack_o(if_d_ack),
    .if_biu_adri_i(if_adri), .if_biu_adro_o(if_adro), .if_biu_size_i(if_size),
    .if_biu_type_i(if_type), .if_biu_prot_i(if_prot), .if_biu_lock_i(if_lock),
    .if_biu_we_i(if_we), .if_biu_d_i(if_d), .if_biu_q_o(if_q),
    .if_biu_ack_o(if_ack), .if_biu_err_o(if_err),
    .dc_biu_stb_i(dc_stb), .dc_biu_stb_ack_o(dc_stb_ack), .dc_biu_d_ack_o(dc_d_ack),
    .dc_biu_adri_i(dc_adri), .dc_biu_adro_o(dc_adro), .dc_biu_size_i(dc_size),
    .dc_biu_type_i(dc_type), .dc_biu_prot_i(dc_prot), .dc_biu_lock_i(dc_lock),
    .dc_biu_we_i(dc_we), .dc_biu_d_i(dc_d), .dc_biu_q_o(dc_q),
    .dc_biu_ack_o(dc_ack), .dc_biu_err_o(dc_err),
    .biu_stb_o(b_stb), .biu_stb_ack_i(b_stb_ack), .biu_d_ack_i(b_d_ack),
    .biu_adri_o(b_adri), .biu_adro_i(b_adro), .biu_size_o(b_size),
    .biu_type_o(b_type), .biu_prot_o(b_prot), .biu_lock_o(b_lock),
    .biu_we_o(b_we), .biu_d_o(b_d), .biu_q_i(b_q),
    .biu_ack_i(b_ack), .biu_err_i(b_err)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  bit m_busy;       // a burst is in flight
  bit m_owner_if;   // owner of current / most recent burst
  int m_left;       // beats still expected
  bit m_rr_if;      // last grant went to if
  bit m_lock_pend;  // previous burst ended locked
  bit m_lock_if;    // who held that lock

  function automatic int beats(input logic [2:0] t);
    if (t < 3'd2) return 1;
    return 2 << (t >> 1);
  endfunction

  function automatic bit pick_if();
    if (m_lock_pend && (m_lock_if ? if_stb : dc_stb)) return m_lock_if;
    if (if_stb && dc_stb) begin
`ifdef BIU_ARB_RR_EN
      return !m_rr_if;
`else
      return 1'b0;
`endif
    end
    return if_stb && !dc_stb;
  endfunction

  always @(negedge clk) begin
    bit sel, e_stb, e_grant;
    if (rst) begin
      m_busy = 0; m_owner_if = 0; m_left = 0; m_rr_if = 1;
      m_lock_pend = 0; m_lock_if = 0;
    end
    sel     = m_busy ? m_owner_if : pick_if();
    e_stb   = !rst && !m_busy && (sel ? if_stb : dc_stb);
    e_grant = e_stb && b_stb_ack;

    chk("m_ctrl", 64'({b_stb, if_stb_ack, dc_stb_ack}),
        64'({e_stb, e_grant && sel, e_grant && !sel}));
    chk("m_resp", 64'({if_ack, dc_ack, if_d_ack, dc_d_ack, if_err, dc_err}),
        64'({m_busy && m_owner_if && b_ack,   m_busy && !m_owner_if && b_ack,
             m_busy && m_owner_if && b_d_ack, m_busy && !m_owner_if && b_d_ack,
             m_busy && m_owner_if && b_err,   m_busy && !m_owner_if && b_err}));
    chk("m_adri", b_adri, sel ? if_adri : dc_adri);
    chk("m_attr", 64'({b_size, b_type, b_prot, b_lock, b_we}),
        sel ? 64'({if_size, if_type, if_prot, if_lock, if_we})
            : 64'({dc_size, dc_type, dc_prot, dc_lock, dc_we}));
    chk("m_wdata", b_d, sel ? if_d : dc_d);
    chk("m_if_q", if_q, b_q);
    chk("m_dc_q", dc_q, b_q);
    chk("m_if_adro", if_adro, m_owner_if ? b_adro : 64'd0);
    chk("m_dc_adro", dc_adro, m_owner_if ? 64'd0 : b_adro);

    // advance to the state seen after the coming rising edge
    if (!rst) begin
      if (!m_busy) begin
        if (e_grant) begin
          m_busy = 1; m_owner_if = sel; m_rr_if = sel; m_lock_pend = 0;
          m_left = beats(sel ? if_type : dc_type);
        end
      end else if (b_err || b_ack) begin
        m_left = b_err ? 0 : m_left - 1;
        if (m_left == 0) begin
          m_busy = 0;
          m_lock_pend = m_owner_if ? if_lock : dc_lock;
          m_lock_if = m_owner_if;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle_inputs();
    if_stb = 0; if_adri = '0; if_size = 3'd3; if_type = 3'd0; if_prot = 3'd0;
    if_lock = 0; if_we = 0; if_d = '0;
    dc_stb = 0; dc_adri = '0; dc_size = 3'd3; dc_type = 3'd0; dc_prot = 3'd0;
    dc_lock = 0; dc_we = 0; dc_d = '0;
    b_stb_ack = 0; b_d_ack = 0; b_adro = '0; b_q = '0; b_ack = 0; b_err = 0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1;
    idle_inputs();
    repeat (2) cyc();
    rst = 0;
  endtask

  initial begin
    // reset state with every input trying to provoke an output
    rst = 1;
    idle_inputs();
    if_stb = 1; dc_stb = 1; b_stb_ack = 1; b_ack = 1; b_err = 1; b_d_ack = 1;
    #2;
    chk("rst_outs", 64'({b_stb, if_stb_ack, dc_stb_ack, if_ack, dc_ack,
                         if_d_ack, dc_d_ack, if_err, dc_err}), 64'd0);
    idle_inputs();
    repeat (2) cyc();
    rst = 0;

    // if SINGLE read
    if_stb = 1; if_adri = 64'h1000;
    #1 chk("t1_stb", 64'(b_stb), 64'd1);
    chk("t1_adri", b_adri, 64'h1000);
    chk("t1_noack", 64'(if_stb_ack), 64'd0);
    cyc(); b_stb_ack = 1;
    #1 chk("t1_sack", 64'({if_stb_ack, dc_stb_ack}), 64'b10);
    cyc(); b_stb_ack = 0; if_stb = 0;
    #1 chk("t1_busy", 64'({b_stb, if_stb_ack}), 64'd0);
    cyc(); b_ack = 1; b_q = 64'hDEAD;
    #1 chk("t1_ack", 64'({if_ack, dc_ack}), 64'b10);
    chk("t1_q", if_q, 64'hDEAD);
    cyc(); b_ack = 1; b_err = 1;
    #1 chk("t1_spurious", 64'({if_ack, dc_ack, if_err, dc_err}), 64'd0);
    cyc(); b_ack = 0; b_err = 0;

    // simultaneous strobes: dc first, if granted right after dc completes
    do_reset();
    dc_stb = 1; if_stb = 1; dc_adri = 64'h2000; if_adri = 64'h1000; b_stb_ack = 1;
    #1 chk("t2_adri", b_adri, 64'h2000);
    chk("t2_sack", 64'({if_stb_ack, dc_stb_ack}), 64'b01);
    cyc(); dc_stb = 0; b_ack = 1;
    #1 chk("t2_dcack", 64'({if_ack, dc_ack, if_stb_ack}), 64'b010);
    cyc(); b_ack = 0;
    #1 chk("t2_ifgnt", 64'({if_stb_ack, dc_stb_ack}), 64'b10);
    chk("t2_adri2", b_adri, 64'h1000);
    cyc(); if_stb = 0; b_stb_ack = 0; b_ack = 1;
    #1 chk("t2_ifack", 64'({if_ack, dc_ack}), 64'b10);
    cyc(); b_ack = 0;

    // dc INCR4 write with if strobing throughout
    do_reset();
    dc_stb = 1; dc_type = 3'b011; dc_we = 1; dc_d = 64'h1111; if_stb = 1; b_stb_ack = 1;
    #1 chk("t3_sack", 64'({if_stb_ack, dc_stb_ack}), 64'b01);
    cyc(); dc_stb = 0;
    for (int i = 0; i < 4; i++) begin
      b_ack = 1; b_d_ack = 1; dc_d = 64'h1111 + 64'(i);
      #1 chk($sformatf("t3_beat%0d", i),
             64'({dc_ack, dc_d_ack, if_ack, if_stb_ack, b_stb}), 64'b11000);
      chk($sformatf("t3_wdata%0d", i), b_d, 64'h1111 + 64'(i));
      cyc();
    end
    b_ack = 0; b_d_ack = 0;
    #1 chk("t3_ifgnt", 64'({if_stb_ack, dc_stb_ack}), 64'b10);
    cyc(); if_stb = 0; b_stb_ack = 0; b_ack = 1;
    cyc(); b_ack = 0;

    // both strobing SINGLE continuously
    do_reset();
    if_stb = 1; dc_stb = 1; b_stb_ack = 1; b_ack = 1;
    for (int i = 0; i < 4; i++) begin
      logic [1:0] e;
`ifdef BIU_ARB_RR_EN
      e = (i % 2 == 1) ? 2'b10 : 2'b01;
`else
      e = 2'b01;
`endif
      #1 chk($sformatf("t4_gnt%0d", i), 64'({if_stb_ack, dc_stb_ack}), 64'(e));
      cyc();
      cyc();
    end
    idle_inputs();

    // if WRAP8 read aborted by error after 3 beats
    do_reset();
    if_stb = 1; if_type = 3'b100; b_stb_ack = 1;
    #1 chk("t5_sack", 64'({if_stb_ack, dc_stb_ack}), 64'b10);
    cyc(); if_stb = 0; b_stb_ack = 0;
    for (int i = 0; i < 3; i++) begin
      b_ack = 1;
      #1 chk($sformatf("t5_ack%0d", i), 64'({if_ack, dc_ack}), 64'b10);
      cyc();
    end
    b_ack = 0; b_err = 1;
    #1 chk("t5_err", 64'({if_err, dc_err, if_ack}), 64'b100);
    cyc(); b_err = 0; dc_stb = 1; b_stb_ack = 1;
    #1 chk("t5_dcgnt", 64'({if_stb_ack, dc_stb_ack}), 64'b01);
    cyc(); dc_stb = 0; b_stb_ack = 0; b_ack = 1;
    cyc(); b_ack = 0;

    // asynchronous reset in the middle of a dc INCR8 burst
    do_reset();
    dc_stb = 1; dc_type = 3'b101; b_stb_ack = 1;
    cyc(); dc_stb = 0; b_stb_ack = 0;
    repeat (3) begin
      b_ack = 1;
      cyc();
    end
    b_ack = 0;
    #1 chk("t6_cnt5", 64'(dut.r_beat_cnt), 64'd5);
    dc_stb = 1; b_stb_ack = 1; b_ack = 1;
    #1 chk("t6_pre", 64'({dc_ack, b_stb}), 64'b10);
    rst = 1;
    #1 chk("t6_rst", 64'({dc_ack, dc_stb_ack, b_stb, if_ack, dc_d_ack, dc_err}), 64'd0);
    cyc(); rst = 0; dc_stb = 0; b_stb_ack = 0; b_ack = 1;
    #1 chk("t6_idle", 64'({dc_ack, if_ack}), 64'd0);
    chk("t6_cnt0", 64'(dut.r_beat_cnt), 64'd0);
    cyc(); idle_inputs();

    // randomized traffic checked by the model every cycle
    do_reset();
    repeat (3000) begin
      cyc();
      rst      = ($urandom_range(0, 199) == 0);
      if_stb   = 1'($urandom_range(0, 1));
      dc_stb   = ($urandom_range(0, 2) == 0);
      if_adri  = {$urandom, $urandom};
      dc_adri  = {$urandom, $urandom};
      if_size  = 3'($urandom_range(0, 7));
      dc_size  = 3'($urandom_range(0, 7));
      if_type  = 3'($urandom_range(0, 7));
      dc_type  = 3'($urandom_range(0, 7));
      if_prot  = 3'($urandom_range(0, 7));
      dc_prot  = 3'($urandom_range(0, 7));
      if_lock  = ($urandom_range(0, 3) == 0);
      dc_lock  = ($urandom_range(0, 3) == 0);
      if_we    = 1'($urandom_range(0, 1));
      dc_we    = 1'($urandom_range(0, 1));
      if_d     = {$urandom, $urandom};
      dc_d     = {$urandom, $urandom};
      b_stb_ack = 1'($urandom_range(0, 1));
      b_d_ack  = 1'($urandom_range(0, 1));
      b_ack    = ($urandom_range(0, 99) < 45);
      b_err    = ($urandom_range(0, 99) < 4);
      b_q      = {$urandom, $urandom};
      b_adro   = {$urandom, $urandom};
    end
    rst = 0;
    idle_inputs();
    repeat (2) cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
